// File: rtl/potential_decay_unit.sv
// Membrane potential store and per-timestep decay sweep feeding the adder.
// Items leave on a valid/ready handshake; final potentials return on wb.
module fp_mul (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              sign;
    logic [7:0]        ea;
    logic [7:0]        eb;
    logic [47:0]       prod;
    logic [22:0]       frac;
    logic              guard;
    logic              sticky;
    logic              rnd;
    logic [23:0]       frac_r;
    logic signed [9:0] exp_v;
    logic              a_zero;
    logic              b_zero;
    logic              a_inf;
    logic              b_inf;
    logic              a_nan;
    logic              b_nan;

    always_comb begin
        sign   = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        a_zero = (ea == 8'h00);
        b_zero = (eb == 8'h00);
        a_inf  = (ea == 8'hff) && (a[22:0] == 23'd0);
        b_inf  = (eb == 8'hff) && (b[22:0] == 23'd0);
        a_nan  = (ea == 8'hff) && (a[22:0] != 23'd0);
        b_nan  = (eb == 8'hff) && (b[22:0] != 23'd0);
        prod   = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        exp_v  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        if (prod[47]) begin
            frac   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_v  = exp_v + 10'sd1;
        end else begin
            frac   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        // round to nearest, ties to even
        rnd    = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {23'd0, rnd};
        if (frac_r[23])
            exp_v = exp_v + 10'sd1;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            y = 32'h7fc00000;
        else if (a_inf || b_inf)
            y = {sign, 8'hff, 23'd0};
        else if (a_zero || b_zero)
            y = {sign, 31'd0};
        else if (exp_v >= 10'sd255)
            y = {sign, 8'hff, 23'd0};
        else if (exp_v <= 10'sd0)
            y = {sign, 31'd0};
        else
            y = {sign, exp_v[7:0], frac_r[22:0]};
    end
endmodule

module potential_decay_unit #(
    parameter int NUM_NEURONS = 16,
    parameter int ID_WIDTH    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                timestep_start,
    input  logic [1:0]          model,
    input  logic [31:0]         decay_rate,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_id,
    output logic [31:0]         decayed_potential,
    input  logic                wb_en,
    input  logic [ID_WIDTH-1:0] wb_addr,
    input  logic [31:0]         wb_data,
    output logic                busy,
    output logic                sweep_done
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_PRESENT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_NEURONS - 1);

    logic [31:0]         entry [NUM_NEURONS];
    logic [1:0]          state;
    logic [ID_WIDTH-1:0] idx;
    logic [1:0]          model_q;
    logic [31:0]         decay_q;
    logic [31:0]         v;
    logic [31:0]         sq;
    logic [31:0]         mul_a;
    logic [31:0]         mul_y;
    logic [31:0]         result;

    assign v     = entry[idx];
    assign mul_a = (model_q == 2'b10) ? sq : v;

    fp_mul u_square (
        .a (v),
        .b (v),
        .y (sq)
    );

    fp_mul u_decay (
        .a (mul_a),
        .b (decay_q),
        .y (mul_y)
    );

    always_comb begin
        result = v;
        unique case (model_q)
            2'b00:   result = mul_y;
            2'b10:   result = mul_y;
            default: result = v;
        endcase
        // a resting neuron stays at +0 whatever the sign of k
        if (v == 32'h00000000)
            result = 32'h00000000;
    end

    assign out_valid  = (state == S_PRESENT);
    assign busy       = (state != S_IDLE);
    assign sweep_done = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            idx               <= '0;
            model_q           <= 2'b00;
            decay_q           <= 32'h0;
            out_id            <= '0;
            decayed_potential <= 32'h0;
            for (int i = 0; i < NUM_NEURONS; i++)
                entry[i] <= 32'h0;
        end else begin
            if (wb_en && (32'(wb_addr) < NUM_NEURONS))
                entry[wb_addr] <= wb_data;
            unique case (state)
                S_IDLE: begin
                    if (timestep_start) begin
                        model_q <= model;
                        decay_q <= decay_rate;
                        idx     <= '0;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    decayed_potential <= result;
                    out_id            <= idx;
                    state             <= S_PRESENT;
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        if (idx == LAST_ID) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_potential_decay_unit.sv
// Directed bench for potential_decay_unit: vector table plus timing,
// backpressure, hazard, reset and short-array sequences.
module tb_potential_decay_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        timestep_start;
    logic [1:0]  model;
    logic [31:0] decay_rate;
    logic        out_ready;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    logic        out_valid, busy, sweep_done;
    logic [3:0]  out_id;
    logic [31:0] decayed_potential;
    logic        out_valid2, busy2, sweep_done2;
    logic [3:0]  out_id2;
    logic [31:0] decayed_potential2;

    always #5 clk = ~clk;

    potential_decay_unit #(.NUM_NEURONS(16), .ID_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .timestep_start(timestep_start),
        .model(model), .decay_rate(decay_rate), .out_valid(out_valid),
        .out_ready(out_ready), .out_id(out_id),
        .decayed_potential(decayed_potential), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy),
        .sweep_done(sweep_done)
    );

    potential_decay_unit #(.NUM_NEURONS(12), .ID_WIDTH(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .timestep_start(timestep_start),
        .model(model), .decay_rate(decay_rate), .out_valid(out_valid2),
        .out_ready(out_ready), .out_id(out_id2),
        .decayed_potential(decayed_potential2), .wb_en(wb_en),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy2),
        .sweep_done(sweep_done2)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    logic [31:0] data1 [16];
    logic [31:0] data2 [16];
    int cnt1, bad1, done1, done_cyc1, first_v1;
    int cnt2, bad2, done2, last2;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (out_valid && first_v1 < 0)
            first_v1 = cyc;
        if (out_valid && out_ready) begin
            if (out_id != 4'(cnt1)) bad1++;
            data1[out_id] = decayed_potential;
            cnt1++;
        end
        if (sweep_done) begin
            done1++;
            done_cyc1 = cyc;
        end
        if (out_valid2 && out_ready) begin
            if (out_id2 != 4'(cnt2)) bad2++;
            data2[out_id2] = decayed_potential2;
            last2 = int'(out_id2);
            cnt2++;
        end
        if (sweep_done2) done2++;
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        for (int i = 0; i < 16; i++) begin
            data1[i] = 32'hdeadbeef;
            data2[i] = 32'hdeadbeef;
        end
        cnt1 = 0; bad1 = 0; done1 = 0; done_cyc1 = -1; first_v1 = -1;
        cnt2 = 0; bad2 = 0; done2 = 0; last2 = -1;
    endtask

    task automatic start_sweep(input logic [1:0] m, input logic [31:0] k,
                               output int t0);
        model = m;
        decay_rate = k;
        timestep_start = 1'b1;
        t0 = cyc;
        step();
        timestep_start = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sweep_done) begin
                seen = 1'b1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL sweep_done timeout: got none within %0d cycles", maxc);
        end
        step();
    endtask

    task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
        wb_en = 1'b1;
        wb_addr = a;
        wb_data = d;
        step();
        wb_en = 1'b0;
    endtask

    function automatic int nonzero1(input int skip);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (i != skip && data1[i] != 32'h0) n++;
        return n;
    endfunction

    typedef struct {
        logic [1:0]  m;
        logic [31:0] k;
        logic [31:0] v3;
        logic [31:0] exp3;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0] = '{2'b00, 32'h3F000000, 32'h40000000, 32'h3F800000};
        vecs[1] = '{2'b10, 32'h3F000000, 32'h40000000, 32'h40000000};
        vecs[2] = '{2'b01, 32'h3F000000, 32'h40000000, 32'h40000000};
        vecs[3] = '{2'b11, 32'h3F000000, 32'h40000000, 32'h40000000};
        vecs[4] = '{2'b00, 32'h40000000, 32'hC0400000, 32'hC0C00000};
        vecs[5] = '{2'b10, 32'h3F000000, 32'hC0400000, 32'h40900000};
        vecs[6] = '{2'b10, 32'h3F000000, 32'h3FC00000, 32'h3F900000};

        rst_n = 1'b0;
        timestep_start = 1'b0;
        model = 2'b00;
        decay_rate = 32'h0;
        out_ready = 1'b1;
        wb_en = 1'b0;
        wb_addr = 4'd0;
        wb_data = 32'h0;
        clear_mon();
        repeat (3) step();
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sweep_done", 32'(sweep_done), 32'd0);
        chk("reset out_id", 32'(out_id), 32'd0);
        chk("reset data", decayed_potential, 32'h0);
        rst_n = 1'b1;
        step();

        // full zero sweep and timing
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        wait_done(60);
        chk("zero count", cnt1, 16);
        chk("zero order", bad1, 0);
        chk("zero data", nonzero1(-1), 0);
        chk("first valid cycle", first_v1, t0 + 2);
        chk("done cycle", done_cyc1, t0 + 33);
        chk("busy after", 32'(busy), 32'd0);

        for (int i = 0; i < 7; i++) begin
            wb_write(4'd3, vecs[i].v3);
            clear_mon();
            start_sweep(vecs[i].m, vecs[i].k, t0);
            wait_done(60);
            chk($sformatf("vec%0d id3", i), data1[3], vecs[i].exp3);
            chk($sformatf("vec%0d count", i), cnt1, 16);
            chk($sformatf("vec%0d others", i), nonzero1(3), 0);
        end
        wb_write(4'd3, 32'h0);

        // backpressure with a write to the held entry
        wb_write(4'd0, 32'h3F800000);
        out_ready = 1'b0;
        clear_mon();
        start_sweep(2'b01, 32'h3F000000, t0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stall%0d id", i), 32'(out_id), 32'd0);
            chk($sformatf("stall%0d data", i), decayed_potential, 32'h3F800000);
            wb_en = (i == 1);
            wb_addr = 4'd0;
            wb_data = 32'h41000000;
            step();
        end
        wb_en = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post-accept valid low", 32'(out_valid), 32'd0);
        step();
        chk("next item valid", 32'(out_valid), 32'd1);
        chk("next item id", 32'(out_id), 32'd1);
        wait_done(60);
        chk("bp count", cnt1, 16);

        // writeback hazards
        wb_write(4'd1, 32'h40000000);
        wb_write(4'd5, 32'h3F800000);
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        step();
        step();
        wb_write(4'd1, 32'h40800000);
        step();
        step();
        wb_write(4'd5, 32'h40800000);
        wait_done(60);
        chk("hazard id1 old", data1[1], 32'h3F800000);
        chk("hazard id5 new", data1[5], 32'h40000000);
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        wait_done(60);
        chk("hazard id1 second", data1[1], 32'h40000000);

        // start while busy is ignored, latched model kept
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        repeat (4) step();
        timestep_start = 1'b1;
        model = 2'b10;
        decay_rate = 32'h40800000;
        step();
        timestep_start = 1'b0;
        wait_done(60);
        repeat (3) step();
        chk("midstart count", cnt1, 16);
        chk("midstart done count", done1, 1);
        chk("midstart busy", 32'(busy), 32'd0);
        chk("midstart id5 lif", data1[5], 32'h40000000);

        // reset mid-sweep
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        repeat (15) step();
        chk("pre-reset valid", 32'(out_valid), 32'd1);
        chk("pre-reset id", 32'(out_id), 32'd7);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset valid", 32'(out_valid), 32'd0);
        chk("reset busy mid", 32'(busy), 32'd0);
        step();
        clear_mon();
        start_sweep(2'b01, 32'h3F000000, t0);
        wait_done(60);
        chk("post-reset count", cnt1, 16);
        chk("post-reset zeros", nonzero1(-1), 0);

        // short array ignores out-of-range writeback
        wb_write(4'd15, 32'h40000000);
        clear_mon();
        start_sweep(2'b00, 32'h3F000000, t0);
        wait_done(60);
        chk("dut id15", data1[15], 32'h3F800000);
        chk("dut2 count", cnt2, 12);
        chk("dut2 order", bad2, 0);
        chk("dut2 last id", last2, 11);
        chk("dut2 done", done2, 1);
        begin
            int nz = 0;
            for (int i = 0; i < 12; i++)
                if (data2[i] != 32'h0) nz++;
            chk("dut2 zeros", nz, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/potential_decay_unit.md
Name: potential_decay_unit

Overview:
- Upstream stage of the potential adder. Holds the membrane potential of every neuron in a local register file.
- On each timestep start, sweeps all neurons in index order. For each one it computes the model-dependent decayed potential and presents it, with its neuron index, on a valid/ready handshake to the adder.
- The adder's final_potential returns through a writeback port, ready for the next timestep.
- All values are IEEE-754 single precision. Arithmetic uses the codebase's combinational float Multiplication unit.

Parameters:
NUM_NEURONS  16  neurons held and swept per timestep
ID_WIDTH  4  width of neuron index; must satisfy 2^ID_WIDTH >= NUM_NEURONS

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset
timestep_start  input  1  one-cycle pulse; begins a sweep when idle
model  input  2  00 LIF, 01 Izhikevich, 10 QLIF, 11 reserved; sampled at accepted start
decay_rate  input  32  float decay factor k; sampled at accepted start
out_valid  output  1  decayed_potential/out_id valid
out_ready  input  1  adder accepts current item
out_id  output  ID_WIDTH  neuron index of presented item
decayed_potential  output  32  decayed float potential
wb_en  input  1  write potential register
wb_addr  input  ID_WIDTH  writeback neuron index
wb_data  input  32  potential to store (adder final_potential)
busy  output  1  high from accepted start until sweep end
sweep_done  output  1  one-cycle pulse after last item accepted

Behaviour:
- Reset, applied when rst_n is low at a clock edge:
  - all outputs go to 0;
  - all NUM_NEURONS potential entries go to 32'h00000000;
  - state goes to IDLE.
- Reset wins over every other input in the same cycle, including mid-sweep; the partial sweep is discarded.
- States:
  - IDLE: busy=0, out_valid=0. timestep_start=1 latches model and decay_rate, sets idx=0, and moves to LOAD.
  - LOAD: reads entry[idx] (registered value, pre-write this cycle) and computes the result:
    - LIF (00): v*k;
    - Izhikevich (01): v (pass-through);
    - QLIF (10): (v*v)*k, using two chained multipliers;
    - reserved (11): v.
  - LOAD then registers decayed_potential and out_id=idx, sets out_valid=1, and moves to PRESENT.
  - PRESENT: holds out_valid, out_id and decayed_potential stable while out_ready=0. On out_valid&&out_ready:
    - if idx==NUM_NEURONS-1: out_valid=0, go to DONE;
    - otherwise: idx+1, go to LOAD.
  - DONE: sweep_done=1 for exactly this cycle, busy falls, then IDLE.
- Latency and throughput:
  - start accepted in cycle T gives out_valid=1 from T+2 (the LOAD cycle is T+1);
  - each neuron costs 2 cycles minimum with out_ready held high;
  - a full sweep takes 2*NUM_NEURONS+1 cycles after start, then IDLE.
- busy is 1 in LOAD, PRESENT and DONE.
- timestep_start while busy is ignored; it is not queued.
- model and decay_rate changes mid-sweep have no effect; the latched values are used.
- Writeback:
  - wb_en writes wb_data to entry[wb_addr] at the clock edge, in any state except reset;
  - wb_addr >= NUM_NEURONS is ignored.
- Hazards:
  - wb in the same cycle as LOAD of that address: LOAD uses the old value; the write still lands.
  - wb to an entry already presented: does not alter the held output.
  - wb to an entry not yet loaded: the later LOAD uses the new value.
- Multiplier exception/overflow/underflow flags are left unconnected. The result bits are passed as the unit produces them.
- The zero potential (32'h00000000) must yield 32'h00000000 in all models.

Test Plan:
- Reset then start, LIF, k=3F000000 (0.5), entries all zero, out_ready=1 -> 16 items, ids 0..15, all decayed_potential=0; sweep_done pulses at cycle T+33; busy low after.
- LIF: wb entry3=40000000 (2.0) before start, k=0.5 -> item id3 = 3F800000 (1.0). QLIF with same values -> id3 = 40000000 (2.0, from 4.0*0.5). Izhikevich -> id3 = 40000000 (pass-through).
- Backpressure: out_ready=0 for 5 cycles while id0=3F800000 is presented -> out_valid, out_id and data stay stable for 5 cycles; next item follows 2 cycles after the accept.
- Hazard checks:
  - wb id1=40800000 (4.0) in id1's LOAD cycle -> presented id1 uses the old value; a second sweep presents 4.0*k.
  - wb id5 during PRESENT of id2 -> id5 uses the new value.
- timestep_start pulsed mid-sweep -> ignored; exactly 16 items and one sweep_done. rst_n=0 during PRESENT of id7 -> next cycle out_valid=0, busy=0, all entries read back as 0 on a fresh sweep.
- wb_addr=15 with NUM_NEURONS=12, ID_WIDTH=4 -> no entry changes; sweep ends after id11.
